// File: rtl/hash_accumulator.sv
`default_nettype none
// hash_accumulator: SHA-256 hash state H0..H7 -- IV load, per-block add, digest valid/ack.
// Build option HASH_ACC_PARALLEL_EN: eight parallel adders, single-cycle accumulate.
module hash_accumulator #(
  parameter int                WORD_W = 32,
  parameter logic [WORD_W-1:0] IV_A   = 32'h6a09e667,
  parameter logic [WORD_W-1:0] IV_B   = 32'hbb67ae85,
  parameter logic [WORD_W-1:0] IV_C   = 32'h3c6ef372,
  parameter logic [WORD_W-1:0] IV_D   = 32'ha54ff53a,
  parameter logic [WORD_W-1:0] IV_E   = 32'h510e527f,
  parameter logic [WORD_W-1:0] IV_F   = 32'h9b05688c,
  parameter logic [WORD_W-1:0] IV_G   = 32'h1f83d9ab,
  parameter logic [WORD_W-1:0] IV_H   = 32'h5be0cd19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  blk_done,
  input  logic                  last,
  input  logic [WORD_W-1:0]     in_A,
  input  logic [WORD_W-1:0]     in_B,
  input  logic [WORD_W-1:0]     in_C,
  input  logic [WORD_W-1:0]     in_D,
  input  logic [WORD_W-1:0]     in_E,
  input  logic [WORD_W-1:0]     in_F,
  input  logic [WORD_W-1:0]     in_G,
  input  logic [WORD_W-1:0]     in_H,
  output logic [WORD_W-1:0]     h_A,
  output logic [WORD_W-1:0]     h_B,
  output logic [WORD_W-1:0]     h_C,
  output logic [WORD_W-1:0]     h_D,
  output logic [WORD_W-1:0]     h_E,
  output logic [WORD_W-1:0]     h_F,
  output logic [WORD_W-1:0]     h_G,
  output logic [WORD_W-1:0]     h_H,
  output logic [8*WORD_W-1:0]   digest,
  output logic                  digest_valid,
  input  logic                  digest_ack,
  output logic                  busy,
  output logic                  err_drop
);

  localparam logic [WORD_W-1:0] IV [8] = '{IV_A, IV_B, IV_C, IV_D, IV_E, IV_F, IV_G, IV_H};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    ACC   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] h     [8];
  logic [WORD_W-1:0] snap  [8];
  logic [WORD_W-1:0] in_w  [8];
  logic              snap_last;
  logic              acc_end;

  assign in_w[0] = in_A;
  assign in_w[1] = in_B;
  assign in_w[2] = in_C;
  assign in_w[3] = in_D;
  assign in_w[4] = in_E;
  assign in_w[5] = in_F;
  assign in_w[6] = in_G;
  assign in_w[7] = in_H;

`ifdef HASH_ACC_PARALLEL_EN
  assign acc_end = 1'b1;
`else
  logic [2:0] cnt;
  assign acc_end = (cnt == 3'd7);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // init has priority over every other event in every state
  always_comb begin
    state_nxt = state;
    if (init) begin
      state_nxt = READY;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        READY:   if (blk_done) state_nxt = ACC;
        ACC:     if (acc_end) state_nxt = snap_last ? DONE : READY;
        DONE:    if (digest_ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        h[i]    <= IV[i];
        snap[i] <= '0;
      end
      snap_last <= 1'b0;
      err_drop  <= 1'b0;
`ifndef HASH_ACC_PARALLEL_EN
      cnt       <= 3'd0;
`endif
    end else if (init) begin
      for (int i = 0; i < 8; i++) h[i] <= IV[i];
      err_drop <= 1'b0;
`ifndef HASH_ACC_PARALLEL_EN
      cnt      <= 3'd0;
`endif
    end else begin
      if (blk_done && (state != READY)) err_drop <= 1'b1;
      if (state == READY && blk_done) begin
        for (int i = 0; i < 8; i++) snap[i] <= in_w[i];
        snap_last <= last;
`ifndef HASH_ACC_PARALLEL_EN
        cnt       <= 3'd0;
`endif
      end
      if (state == ACC) begin
`ifdef HASH_ACC_PARALLEL_EN
        for (int i = 0; i < 8; i++) h[i] <= h[i] + snap[i];
`else
        // single shared adder walks H0..H7; cnt wraps back to 0 after word 7
        h[cnt] <= h[cnt] + snap[cnt];
        cnt    <= cnt + 3'd1;
`endif
      end
    end
  end

  assign h_A = h[0];
  assign h_B = h[1];
  assign h_C = h[2];
  assign h_D = h[3];
  assign h_E = h[4];
  assign h_F = h[5];
  assign h_G = h[6];
  assign h_H = h[7];

  assign digest       = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  assign digest_valid = (state == DONE);
  assign busy         = (state == ACC);

endmodule
`default_nettype wire

// File: tb/tb_hash_accumulator.sv
`default_nettype none
// tb_hash_accumulator: directed checks of IV load, block accumulate, digest handshake and errors.
module tb_hash_accumulator;

`ifdef HASH_ACC_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 8;
`endif

  localparam logic [255:0] IV_ALL =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b0, blk_done = 1'b0, last = 1'b0, digest_ack = 1'b0;
  logic [31:0] in_w [8];
  logic [31:0] h_A, h_B, h_C, h_D, h_E, h_F, h_G, h_H;
  logic [255:0] digest;
  logic        digest_valid, busy, err_drop;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  hash_accumulator dut (
    .clk(clk), .rst(rst), .init(init), .blk_done(blk_done), .last(last),
    .in_A(in_w[0]), .in_B(in_w[1]), .in_C(in_w[2]), .in_D(in_w[3]),
    .in_E(in_w[4]), .in_F(in_w[5]), .in_G(in_w[6]), .in_H(in_w[7]),
    .h_A(h_A), .h_B(h_B), .h_C(h_C), .h_D(h_D), .h_E(h_E), .h_F(h_F), .h_G(h_G), .h_H(h_H),
    .digest(digest), .digest_valid(digest_valid), .digest_ack(digest_ack),
    .busy(busy), .err_drop(err_drop)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] a, b, c, d, e, f, g, hh);
    in_w[0] = a; in_w[1] = b; in_w[2] = c; in_w[3] = d;
    in_w[4] = e; in_w[5] = f; in_w[6] = g; in_w[7] = hh;
  endtask

  task automatic do_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic do_blk(input logic lst);
    blk_done = 1'b1;
    last = lst;
    tick();
    blk_done = 1'b0;
    last = 1'b0;
  endtask

  task automatic do_ack();
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_digest", digest, IV_ALL);
    chk("reset_valid", digest_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err_drop, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single block, all inputs 1
    do_init();
    chk("t1_hA_iv", h_A, 32'h6a09e667);
    set_in(1, 1, 1, 1, 1, 1, 1, 1);
    do_blk(1'b1);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      chk("t1_valid_early", digest_valid, 0);
    end
    tick();
    chk("t1_valid", digest_valid, 1);
    chk("t1_digest", digest,
        256'h6a09e668_bb67ae86_3c6ef373_a54ff53b_510e5280_9b05688d_1f83d9ac_5be0cd1a);
    chk("t1_busy_off", busy, 0);
    do_ack();
    chk("t1_ack", digest_valid, 0);

    // mod 2^32 wrap in H0, no carry into H1
    do_init();
    set_in(32'hffffffff, 0, 0, 0, 0, 0, 0, 0);
    do_blk(1'b1);
    repeat (LAT) tick();
    chk("t2_digest", digest,
        256'h6a09e666_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);
    do_ack();

    // two blocks
    do_init();
    set_in(1, 1, 1, 1, 1, 1, 1, 1);
    do_blk(1'b0);
    repeat (LAT) tick();
    chk("t3_mid_valid", digest_valid, 0);
    chk("t3_mid_busy", busy, 0);
    chk("t3_mid_hA", h_A, 32'h6a09e668);
    set_in(2, 2, 2, 2, 2, 2, 2, 2);
    do_blk(1'b1);
    repeat (LAT) tick();
    chk("t3_valid", digest_valid, 1);
    chk("t3_digest", digest,
        256'h6a09e66a_bb67ae88_3c6ef375_a54ff53d_510e5282_9b05688f_1f83d9ae_5be0cd1c);
    do_ack();

    // "abc" final working variables
    do_init();
    set_in(32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
           32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894);
    do_blk(1'b1);
    repeat (LAT) tick();
    chk("t4_abc", digest,
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    do_ack();
    chk("t4_idle_valid", digest_valid, 0);

    // dropped blk_done in IDLE, then mid-ACC
    set_in(5, 5, 5, 5, 5, 5, 5, 5);
    do_blk(1'b1);
    chk("t5_idle_err", err_drop, 1);
    chk("t5_idle_h", digest,
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    do_init();
    chk("t5_init_err", err_drop, 0);
    chk("t5_init_h", digest, IV_ALL);
    set_in(1, 1, 1, 1, 1, 1, 1, 1);
    do_blk(1'b1);
    tick();
    set_in(9, 9, 9, 9, 9, 9, 9, 9);
    do_blk(1'b1);
    chk("t5_acc_err", err_drop, 1);
    begin
      int n = 0;
      while (!digest_valid && n < 20) begin
        tick();
        n++;
      end
    end
    chk("t5_valid", digest_valid, 1);
    chk("t5_digest", digest,
        256'h6a09e668_bb67ae86_3c6ef373_a54ff53b_510e5280_9b05688d_1f83d9ac_5be0cd1a);
    do_ack();

    // async reset mid-accumulate
    do_init();
    set_in(7, 7, 7, 7, 7, 7, 7, 7);
    do_blk(1'b1);
    do_blk(1'b1);
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_digest", digest, IV_ALL);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", digest_valid, 0);
    chk("t6_rst_err", err_drop, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // init and blk_done together in READY
    do_init();
    init = 1'b1;
    blk_done = 1'b1;
    last = 1'b1;
    tick();
    init = 1'b0;
    blk_done = 1'b0;
    last = 1'b0;
    chk("t6_both_busy", busy, 0);
    chk("t6_both_err", err_drop, 0);
    chk("t6_both_h", digest, IV_ALL);
    tick();
    chk("t6_no_acc", busy, 0);
    repeat (LAT + 1) tick();
    chk("t6_hold_h", digest, IV_ALL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
